seq_gen: RTL
============

Name: seq_gen

Overview:
- Pattern generator that drives the A/B two-wire symbol interface.
- On a start request, emits the fixed frame A,B,B,A,A on outputs A/B, one symbol per slot.
- Repeats the frame a programmable number of times, then reports completion.
- Serves as the transmit end of the A/B pattern interface, for stimulus and for board-level self-test of the pattern detector.

Parameters:
- SYM_CYC, 1: clock cycles each symbol is held on A/B (legal values ≥1).
- GAP_CYC, 0: idle cycles (A=B=0) inserted between consecutive frames; 0 means frames are back-to-back.
- CNT_W, 8: width of the repeat and frame counters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  request to begin transmission; sampled only in IDLE.
- repeat_n  in  CNT_W  number of frames to send; latched at start; 0 is treated as 1.
- abort  in  1  terminate the transmission immediately.
- A  out  1  symbol line A, registered.
- B  out  1  symbol line B, registered.
- busy  out  1  high while a transmission is in progress.
- done  out  1  one-cycle pulse after the final symbol of the final frame.
- frame_cnt  out  CNT_W  number of frames completed in the current or most recent transmission.

Behaviour:
- Reset values: A=0, B=0, busy=0, done=0, frame_cnt=0; FSM in IDLE.
- Symbol encoding: SYM_A gives A=1,B=0. SYM_B gives A=0,B=1. Idle gives A=0,B=0. A and B are never both high.
- States:
  - IDLE: outputs low. On start=1 and abort=0:
    - latch frames = (repeat_n==0 ? 1 : repeat_n);
    - clear sym_idx, hold_cnt and frame_cnt;
    - go to SEND.
  - SEND: drive pattern[sym_idx] for SYM_CYC cycles, then advance sym_idx. After the last hold cycle of sym_idx=4:
    - frame_cnt increments;
    - if frame_cnt+1==frames, go to DONE;
    - else if GAP_CYC>0, go to GAP;
    - else go to SEND with sym_idx=0 (no idle cycle between frames).
  - GAP: A=B=0 for exactly GAP_CYC cycles, then SEND with sym_idx=0.
  - DONE: A=B=0, done=1 for exactly one cycle, then IDLE.
- Latency: the first symbol appears on A/B in the cycle after the edge on which start is sampled.
- busy is high in SEND and GAP only; it is low in the DONE cycle.
- Frame length is 5×SYM_CYC cycles. Total busy length is frames×5×SYM_CYC + (frames−1)×GAP_CYC.
- start while busy or in DONE is ignored; it is not queued.
- abort in SEND or GAP: on the next edge A=B=0, busy=0, go to IDLE. No done pulse. frame_cnt holds its value.
- abort and start together in IDLE: abort wins and start is ignored.
- abort in DONE: done still pulses, then IDLE.
- Counters:
  - hold_cnt is wide enough for SYM_CYC−1 and GAP_CYC−1.
  - frame_cnt saturates at 2^CNT_W−1 and does not wrap.
- Asserting rstn mid-frame forces the reset values asynchronously. No partial frame completes after reset.

Optional Feature:
- Macro: SEQ_GEN_PROG_PAT_EN.
- Defined:
  - adds input pat [9:0], holding five 2-bit symbols {A,B}, with symbol 0 in pat[9:8];
  - pat is latched at start and used for all frames;
  - symbol value 2'b11 is replaced by 2'b00, so A and B are never both high.
- Undefined: no pat port; the pattern is the fixed constant A,B,B,A,A.

Decomposition:
- Package seq_pkg contains:
  - state enum {IDLE, SEND, GAP, DONE};
  - 2-bit symbol typedef and constants SYM_IDLE, SYM_A, SYM_B;
  - SEQ_LEN=5;
  - default pattern constant DEF_PAT.
- One sub-module is natural: seq_sym_timer, a loadable down-counter with a terminal-count output. It sets both the symbol-hold and the gap duration.

Test Plan:
- SYM_CYC=1, GAP_CYC=0, repeat_n=1, start at cycle 0:
  - A=1 in cycle 1;
  - B=1 in cycles 2–3;
  - A=1 in cycles 4–5;
  - done=1 in cycle 6;
  - busy=1 in cycles 1–5;
  - frame_cnt=1.
- SYM_CYC=3, GAP_CYC=2, repeat_n=2:
  - each symbol is held 3 cycles;
  - 2 idle cycles separate the frames;
  - busy spans 32 cycles;
  - done fires once;
  - frame_cnt=2.
- repeat_n=0 → exactly one frame is sent, done pulses once, frame_cnt=1.
- abort during the third symbol of frame 1 → A=B=0 on the next cycle, busy=0, no done, frame_cnt=0. A start pulse sent during the busy period before the abort has no effect.
- start pulse while busy, and rstn asserted mid-frame:
  - start while busy leaves the transmission unchanged;
  - rstn forces all outputs to 0 immediately;
  - a start after reset begins a fresh frame at sym_idx 0.
- With SEQ_GEN_PROG_PAT_EN defined and pat=10'b11_01_10_00_01:
  - the output sequence is idle, B, A, idle, B;
  - A and B are never high together.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, symbol constants and pattern helpers for seq_gen
package seq_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  // symbols are packed {A,B}
  typedef logic [1:0] sym_t;

  localparam sym_t SYM_IDLE = 2'b00;
  localparam sym_t SYM_A    = 2'b10;
  localparam sym_t SYM_B    = 2'b01;

  localparam int SEQ_LEN = 5;
  localparam int PAT_W   = 2 * SEQ_LEN;

  // symbol 0 lives in the top two bits: A,B,B,A,A
  localparam logic [PAT_W-1:0] DEF_PAT = {SYM_A, SYM_B, SYM_B, SYM_A, SYM_A};

  function automatic sym_t clean_sym(input sym_t s);
    return (s == 2'b11) ? SYM_IDLE : s;
  endfunction

  function automatic logic [PAT_W-1:0] clean_pat(input logic [PAT_W-1:0] p);
    logic [PAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      r[2*i +: 2] = clean_sym(p[2*i +: 2]);
    end
    return r;
  endfunction

  function automatic sym_t pat_sym(input logic [PAT_W-1:0] p, input logic [2:0] idx);
    sym_t s;
    case (idx)
      3'd0:    s = p[9:8];
      3'd1:    s = p[7:6];
      3'd2:    s = p[5:4];
      3'd3:    s = p[3:2];
      3'd4:    s = p[1:0];
      default: s = SYM_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_sym_timer.sv
// rtl/seq_sym_timer.sv - loadable down-counter timing symbol holds and inter-frame gaps
// tc is high while the count sits at zero, i.e. on the last cycle of a loaded interval.
module seq_sym_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - A/B symbol frame generator with repeat count, gaps and abort
// Optional SEQ_GEN_PROG_PAT_EN adds a pat input latched at start in place of DEF_PAT.
module seq_gen
  import seq_pkg::*;
#(
  parameter int SYM_CYC = 1,
  parameter int GAP_CYC = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             abort,
`ifdef SEQ_GEN_PROG_PAT_EN
  input  logic [PAT_W-1:0] pat,
`endif
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int HOLD_MAX = ((SYM_CYC > GAP_CYC) ? SYM_CYC : GAP_CYC) - 1;
  localparam int HOLD_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [HOLD_W-1:0] SYM_LOAD = HOLD_W'(SYM_CYC - 1);
  localparam logic [HOLD_W-1:0] GAP_LOAD = HOLD_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 1);

  state_t           state, state_n;
  logic [2:0]       sym_idx, sym_idx_n;
  logic [CNT_W-1:0] frames;
  logic [PAT_W-1:0] pat_q, pat_n, pat_in;
  logic             tmr_load, tmr_tc;
  logic [HOLD_W-1:0] tmr_val;
  logic             start_ok, frame_end, last_frame;
  logic [CNT_W:0]   cnt_inc;
  sym_t             sym_n;
  logic             busy_n, done_n;

`ifdef SEQ_GEN_PROG_PAT_EN
  assign pat_in = clean_pat(pat);
`else
  assign pat_in = DEF_PAT;
`endif

  assign start_ok   = start && !abort;
  assign cnt_inc    = {1'b0, frame_cnt} + 1'b1;
  assign last_frame = (cnt_inc == {1'b0, frames});
  // abort on the final hold cycle discards the frame, so frame_cnt must not move
  assign frame_end  = (state == SEND) && tmr_tc && (sym_idx == LAST_IDX) && !abort;
  assign pat_n      = (state == IDLE && start_ok) ? pat_in : pat_q;

  seq_sym_timer #(.W(HOLD_W)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      sym_idx   <= '0;
      frames    <= '0;
      pat_q     <= DEF_PAT;
      frame_cnt <= '0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state   <= state_n;
      sym_idx <= sym_idx_n;
      pat_q   <= pat_n;
      {A, B}  <= sym_n;
      busy    <= busy_n;
      done    <= done_n;
      if (state == IDLE && start_ok) begin
        frames    <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
        frame_cnt <= '0;
      end else if (frame_end && frame_cnt != '1) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    sym_idx_n = sym_idx;
    tmr_load  = 1'b0;
    tmr_val   = SYM_LOAD;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_n   = SEND;
          sym_idx_n = '0;
          tmr_load  = 1'b1;
        end
      end
      SEND: begin
        if (abort) begin
          state_n = IDLE;
        end else if (tmr_tc) begin
          tmr_load = 1'b1;
          if (sym_idx == LAST_IDX) begin
            sym_idx_n = '0;
            if (last_frame) begin
              state_n = DONE;
            end else if (GAP_CYC > 0) begin
              state_n = GAP;
              tmr_val = GAP_LOAD;
            end
          end else begin
            sym_idx_n = sym_idx + 1'b1;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_n = IDLE;
        end else if (tmr_tc) begin
          state_n   = SEND;
          sym_idx_n = '0;
          tmr_load  = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // outputs are registered, so they are decoded from the next state
  always_comb begin
    sym_n  = SYM_IDLE;
    busy_n = 1'b0;
    done_n = 1'b0;
    if (state_n == SEND) begin
      sym_n = pat_sym(pat_n, sym_idx_n);
    end
    busy_n = (state_n == SEND) || (state_n == GAP);
    done_n = (state_n == DONE);
  end

endmodule
